// File: rtl/pong_match_ctrl_if.sv
// Point-event / score bus between ball logic (master) and match controller (slave).
interface pong_match_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4
);
  localparam int PW = $clog2(NUM_PLAYERS);

  logic                           point_valid;
  logic [PW-1:0]                  point_player;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [PW-1:0]                  last_scorer;
  logic [PW-1:0]                  winner;
  logic                           game_over;

  modport master (
    output point_valid, point_player,
    input  scores, last_scorer, winner, game_over
  );
  modport slave (
    input  point_valid, point_player,
    output scores, last_scorer, winner, game_over
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: coin start, serve delay, per-player scores, win detection.
// Optional feature macro: PONG_DEUCE_EN (win also needs a 2-point lead over every
// other player, or a saturated score).
module pong_match_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_A        = 11,
  parameter int WIN_B        = 15,
  parameter int SERVE_FRAMES = 60
) (
  input  logic              clk7_159,
  input  logic              _rst,
  input  logic              coin_sw,
  input  logic [7:0]        dip_sw,
  input  logic              vblank,
  pong_match_ctrl_if.slave  bus,
  output logic              attract,
  output logic              _attract,
  output logic              serve,
  output logic              _serve,
  output logic              srst,
  output logic              _srst,
  output logic              rst_speed
);
  localparam int PW = $clog2(NUM_PLAYERS);
  localparam int TW = $clog2(SERVE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {S_ATTRACT, S_START, S_SERVE_WAIT, S_PLAY, S_POINT} state_t;
  state_t state, state_nxt;

  logic [2:0]                             coin_sync;
  logic                                   vblank_q;
  logic                                   coin_evt, frame_tick, point_ok;
  logic                                   sw_load, sw_entry, win;
  logic [TW-1:0]                          timer;
  logic [PW-1:0]                          player_q, last_q, winner_q;
  logic                                   game_over_q;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_q;
  logic [SCORE_W-1:0]                     cur_score, new_score;
  int                                     target;
  logic [6:0]                             unused_dip;

  assign unused_dip = dip_sw[7:1];
  assign coin_evt   = coin_sync[1] & ~coin_sync[2];
  assign frame_tick = vblank & ~vblank_q;

  // Out-of-range players only exist when NUM_PLAYERS is not a power of two.
  generate
    if ((1 << PW) == NUM_PLAYERS) begin : g_pow2
      assign point_ok = 1'b1;
    end else begin : g_range
      assign point_ok = (bus.point_player < PW'(NUM_PLAYERS));
    end
  endgenerate

  // Coin synchroniser plus edge history; vblank edge history.
  always_ff @(posedge clk7_159 or negedge _rst) begin
    if (!_rst) begin
      coin_sync <= '0;
      vblank_q  <= 1'b0;
    end else begin
      coin_sync <= {coin_sync[1:0], coin_sw};
      vblank_q  <= vblank;
    end
  end

  // State register.
  always_ff @(posedge clk7_159 or negedge _rst) begin
    if (!_rst) state <= S_ATTRACT;
    else       state <= state_nxt;
  end

  // Next state; sw_load marks every entry into SERVE_WAIT.
  always_comb begin
    state_nxt = state;
    sw_load   = 1'b0;
    case (state)
      S_ATTRACT:    if (coin_evt) state_nxt = S_START;
      S_START:      begin state_nxt = S_SERVE_WAIT; sw_load = 1'b1; end
      S_SERVE_WAIT: if (frame_tick && timer == TW'(1)) state_nxt = S_PLAY;
      S_PLAY:       if (bus.point_valid && point_ok) state_nxt = S_POINT;
      S_POINT: begin
        if (win) state_nxt = S_ATTRACT;
        else begin state_nxt = S_SERVE_WAIT; sw_load = 1'b1; end
      end
      default:      state_nxt = S_ATTRACT;
    endcase
  end

  // Saturating increment of the latched player's score and the win rule.
  always_comb begin
    cur_score = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (player_q == PW'(p)) cur_score = score_q[p];
    new_score = (cur_score == SCORE_MAX) ? cur_score : cur_score + 1'b1;
    target    = dip_sw[0] ? WIN_B : WIN_A;
    win       = (int'(new_score) >= target);
`ifdef PONG_DEUCE_EN
    begin
      logic lead_ok;
      lead_ok = 1'b1;
      for (int p = 0; p < NUM_PLAYERS; p++)
        if (player_q != PW'(p) && int'(new_score) < int'(score_q[p]) + 2) lead_ok = 1'b0;
      win = win && (lead_ok || new_score == SCORE_MAX);
    end
`endif
  end

  // Serve timer, player latch, scores and match result.
  always_ff @(posedge clk7_159 or negedge _rst) begin
    if (!_rst) begin
      timer       <= '0;
      sw_entry    <= 1'b0;
      player_q    <= '0;
      last_q      <= '0;
      winner_q    <= '0;
      game_over_q <= 1'b0;
      score_q     <= '0;
    end else begin
      sw_entry <= sw_load;
      if (sw_load) timer <= TW'(SERVE_FRAMES);
      else if (state == S_SERVE_WAIT && frame_tick) timer <= timer - 1'b1;
      if (state == S_PLAY && bus.point_valid && point_ok) player_q <= bus.point_player;
      if (state == S_START) begin
        score_q     <= '0;
        game_over_q <= 1'b0;
      end
      if (state == S_POINT) begin
        for (int p = 0; p < NUM_PLAYERS; p++)
          if (player_q == PW'(p)) score_q[p] <= new_score;
        last_q <= player_q;
        if (win) begin
          winner_q    <= player_q;
          game_over_q <= 1'b1;
        end
      end
    end
  end

  // Registered strobes: one cycle behind the state they decode.
  always_ff @(posedge clk7_159 or negedge _rst) begin
    if (!_rst) begin
      attract   <= 1'b1;
      serve     <= 1'b0;
      srst      <= 1'b0;
      rst_speed <= 1'b0;
    end else begin
      attract   <= (state == S_ATTRACT);
      serve     <= (state == S_PLAY);
      srst      <= (state == S_START);
      rst_speed <= sw_entry;
    end
  end

  assign _attract        = ~attract;
  assign _serve          = ~serve;
  assign _srst           = ~srst;
  assign bus.scores      = score_q;
  assign bus.last_scorer = last_q;
  assign bus.winner      = winner_q;
  assign bus.game_over   = game_over_q;
endmodule
